// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU execute stage: ALU opcodes, control encodings,
// multiplier state type and the EX/MEM pipeline register layout.
package cpu_pkg;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluNor   = 4'd4;
  localparam logic [3:0] AluSlt   = 4'd5;
  localparam logic [3:0] AluSltu  = 4'd6;
  localparam logic [3:0] AluSll   = 4'd7;
  localparam logic [3:0] AluSrl   = 4'd8;
  localparam logic [3:0] AluLui   = 4'd9;
  localparam logic [3:0] AluMullo = 4'd10;
  localparam logic [3:0] AluMulhi = 4'd11;

  localparam logic [1:0] DrwNone  = 2'd0;
  localparam logic [1:0] DrwRead  = 2'd1;
  localparam logic [1:0] DrwWrite = 2'd2;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbJal = 2'd2;

  localparam int unsigned MUL_ITERS = 32;

  typedef enum logic [1:0] {MulIdle, MulBusy, MulDone} mul_state_e;

  typedef struct packed {
    logic        c_rfw;
    logic [1:0]  c_wbsource;
    logic [1:0]  c_drw;
    logic [31:0] alu_r;
    logic [31:0] rfb;
    logic [4:0]  rf_waddr;
    logic [4:0]  rt;
    logic [31:0] jalra;
  } ex_mem_t;

  // MEM beats WB; register 0 never forwards.
  function automatic logic [31:0] fwd_operand(input logic [4:0]  src,
                                              input logic        mem_rfw,
                                              input logic [4:0]  mem_addr,
                                              input logic [31:0] mem_data,
                                              input logic        wb_rfw,
                                              input logic [4:0]  wb_addr,
                                              input logic [31:0] wb_data,
                                              input logic [31:0] rf_data);
    if (mem_rfw && (mem_addr == src) && (mem_addr != 5'd0)) return mem_data;
    if (wb_rfw && (wb_addr == src) && (wb_addr != 5'd0)) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/cpu_ex_mul.sv
// Iterative 32x32 unsigned shift-add multiplier with IDLE/BUSY/DONE control.
// All state is frozen while stall_i is high.
module cpu_ex_mul
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  localparam logic [4:0] CntLast = 5'(MUL_ITERS - 1);

  mul_state_e  state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= MulIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (!stall_i) begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      MulIdle: begin
        if (start_i) begin
          state_d  = MulBusy;
          mcand_d  = {32'd0, a_i};
          mplier_d = b_i;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      MulBusy: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CntLast) state_d = MulDone;
      end
      MulDone: state_d = MulIdle;
      default: state_d = MulIdle;
    endcase
  end

  assign busy_o    = (state_q == MulBusy);
  assign done_o    = (state_q == MulDone);
  assign product_o = prod_q;

endmodule

// File: rtl/cpu_ex.sv
// Execute stage: operand forwarding, ALU and EX/MEM pipeline register.
// Define CPU_EX_MUL_EN to build the iterative multiplier; otherwise mul ops return 0.
module cpu_ex
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  input  logic        id_c_rfw,
  input  logic [1:0]  id_c_wbsource,
  input  logic [1:0]  id_c_drw,
  input  logic [3:0]  id_c_alucontrol,
  input  logic        id_c_alusrc,
  input  logic [31:0] id_rfa,
  input  logic [31:0] id_rfb,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rf_waddr,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_jalra,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] wb_wdata,
  input  logic        wb_c_rfw,
  input  logic [4:0]  wb_rf_waddr,
  output logic        p_c_rfw,
  output logic [1:0]  p_c_wbsource,
  output logic [1:0]  p_c_drw,
  output logic [31:0] p_alu_r,
  output logic [31:0] p_rfb,
  output logic [4:0]  p_rf_waddr,
  output logic [4:0]  p_rt,
  output logic [31:0] p_jalra,
  output logic        ex_stall
);

  ex_mem_t     pipe_q, pipe_d;
  logic [31:0] op_a, fwd_b, op_b, alu_r;
  logic [31:0] mul_lo, mul_hi;
  logic        is_mul;

  assign op_a  = fwd_operand(id_rs, pipe_q.c_rfw, pipe_q.rf_waddr, mem_wdata,
                             wb_c_rfw, wb_rf_waddr, wb_wdata, id_rfa);
  assign fwd_b = fwd_operand(id_rt, pipe_q.c_rfw, pipe_q.rf_waddr, mem_wdata,
                             wb_c_rfw, wb_rf_waddr, wb_wdata, id_rfb);
  assign op_b   = id_c_alusrc ? id_imm : fwd_b;
  assign is_mul = (id_c_alucontrol == AluMullo) || (id_c_alucontrol == AluMulhi);

`ifdef CPU_EX_MUL_EN
  logic        mul_busy, mul_done;
  logic [63:0] mul_product;

  // Operands are latched inside the multiplier at start, since forwarding sources move on.
  cpu_ex_mul u_mul (
    .clk_i     (clk),
    .rst_ni    (rst),
    .stall_i   (cpu_stall),
    .start_i   (is_mul & ~mul_busy & ~mul_done),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign ex_stall = mul_busy | (is_mul & ~mul_done);
  assign mul_lo   = mul_product[31:0];
  assign mul_hi   = mul_product[63:32];
`else
  assign ex_stall = 1'b0;
  assign mul_lo   = '0;
  assign mul_hi   = '0;
`endif

  always_comb begin
    alu_r = '0;
    case (id_c_alucontrol)
      AluAdd:   alu_r = op_a + op_b;
      AluSub:   alu_r = op_a - op_b;
      AluAnd:   alu_r = op_a & op_b;
      AluOr:    alu_r = op_a | op_b;
      AluNor:   alu_r = ~(op_a | op_b);
      AluSlt:   alu_r = {31'd0, $signed(op_a) < $signed(op_b)};
      AluSltu:  alu_r = {31'd0, op_a < op_b};
      AluSll:   alu_r = op_b << id_imm[10:6];
      AluSrl:   alu_r = op_b >> id_imm[10:6];
      AluLui:   alu_r = {op_b[15:0], 16'h0};
      AluMullo: alu_r = mul_lo;
      AluMulhi: alu_r = mul_hi;
      default:  alu_r = '0;
    endcase
  end

  // A stalled stage emits an all-zero bubble.
  always_comb begin
    pipe_d = '0;
    if (!ex_stall) begin
      pipe_d.c_rfw      = id_c_rfw;
      pipe_d.c_wbsource = id_c_wbsource;
      pipe_d.c_drw      = id_c_drw;
      pipe_d.alu_r      = alu_r;
      pipe_d.rfb        = fwd_b;
      pipe_d.rf_waddr   = id_rf_waddr;
      pipe_d.rt         = id_rt;
      pipe_d.jalra      = id_jalra;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_q <= '0;
    end else if (!cpu_stall) begin
      pipe_q <= pipe_d;
    end
  end

  assign p_c_rfw      = pipe_q.c_rfw;
  assign p_c_wbsource = pipe_q.c_wbsource;
  assign p_c_drw      = pipe_q.c_drw;
  assign p_alu_r      = pipe_q.alu_r;
  assign p_rfb        = pipe_q.rfb;
  assign p_rf_waddr   = pipe_q.rf_waddr;
  assign p_rt         = pipe_q.rt;
  assign p_jalra      = pipe_q.jalra;

endmodule
